// File: rtl/interval_pkg.sv
// Shared constants, FSM state type and one-hot helper for the
// fp16 interval classifier and its occupancy histogram.
package interval_pkg;

  localparam int NUM_BINS = 8;
  localparam int FP16_W   = 16;
  localparam int CNT_W    = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    DUMP  = 1'b1
  } hist_state_e;

  // True when exactly one bit of v is set.
  function automatic logic onehot_ok(
    input logic [31:0] v
  );
    return (v != '0) &&
           ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/interval_histogram_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk_i, rst_ni (async low), clr_i, inc_i, q_o.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= '0;
    end else if (clr_i) begin
      q_o <= '0;
    end else if (inc_i && (q_o != '1)) begin
      q_o <= q_o + 1'b1;
    end
  end

endmodule

// File: rtl/interval_histogram.sv
// Per-interval occupancy histogram fed by one-hot classifier beats,
// with a valid/ready read-and-clear dump of every bin.
// Ports: clk_i, rst_ni, in_valid_i/in_ready_o/interval_i input beats,
// clear_i, dump_req_i, dump_valid_o/dump_ready_i/dump_bin_o/
// dump_count_o/dump_last_o readout, busy_o, error_o.
module interval_histogram #(
  parameter  int NUM_BINS  = interval_pkg::NUM_BINS,
  parameter  int CNT_WIDTH = interval_pkg::CNT_W,
  localparam int BIN_W     = $clog2(NUM_BINS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [NUM_BINS-1:0]  interval_i,
  input  logic                 clear_i,
  input  logic                 dump_req_i,
  output logic                 dump_valid_o,
  input  logic                 dump_ready_i,
  output logic [BIN_W-1:0]     dump_bin_o,
  output logic [CNT_WIDTH-1:0] dump_count_o,
  output logic                 dump_last_o,
  output logic                 busy_o,
  output logic                 error_o
);

  import interval_pkg::*;

  localparam logic [BIN_W-1:0] LAST_IDX =
    BIN_W'(NUM_BINS - 1);

  hist_state_e      state_q, state_d;
  logic [BIN_W-1:0] index_q, index_d;

  logic [CNT_WIDTH-1:0] cnt [NUM_BINS];
  logic [31:0]          iv;
  logic                 ok;
  logic                 accept;
  logic                 hs;
  logic                 last;

  always_comb begin
    iv = '0;
    iv[NUM_BINS-1:0] = interval_i;
  end

  assign ok     = onehot_ok(iv);
  assign accept = in_valid_i && in_ready_o;
  assign hs     = dump_valid_o && dump_ready_i;
  assign last   = (index_q == LAST_IDX);

  // Bins are zeroed as they are read, or all at once on clear.
  for (genvar k = 0; k < NUM_BINS; k++) begin : g_bin
    sat_counter #(
      .WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clear_i ||
               (hs && (index_q == BIN_W'(k)))),
      .inc_i  (accept && ok && interval_i[k]),
      .q_o    (cnt[k])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ACCUM;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    if (clear_i) begin
      state_d = ACCUM;
      index_d = '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (dump_req_i) begin
            state_d = DUMP;
            index_d = '0;
          end
        end
        DUMP: begin
          if (hs) begin
            if (last) begin
              state_d = ACCUM;
              index_d = '0;
            end else begin
              index_d = index_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ACCUM;
          index_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      error_o <= 1'b0;
    end else if (clear_i) begin
      error_o <= 1'b0;
    end else if (hs && last) begin
      error_o <= 1'b0;
    end else if (accept && !ok) begin
      error_o <= 1'b1;
    end
  end

  assign in_ready_o   = (state_q == ACCUM);
  assign dump_valid_o = (state_q == DUMP);
  assign busy_o       = dump_valid_o;
  assign dump_bin_o   = index_q;
  assign dump_last_o  = dump_valid_o && last;
  assign dump_count_o = dump_valid_o ?
                        cnt[index_q] : '0;

endmodule
